// File: rtl/imem_boot_loader.sv
// Boot loader: big-endian byte stream (16-bit word count, payload, XOR checksum) -> IMEM write port.
// Writes land 1 cycle after a word's 4th byte; in_ready is state-only, low once the load is DONE/ERROR.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  busy,
  output logic                  cpu_run,
  output logic                  error
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [ADDR_WIDTH:0] WL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  accept;
  logic [15:0]           len_in;
  logic [ADDR_WIDTH:0]   wl_next;
  logic [15:0]           wl_next_ext;

  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
  assign busy     = (state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign cpu_run  = (state_q == S_DONE);
  assign error    = (state_q == S_ERROR);

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = wl_q;

  assign accept      = in_valid && in_ready;
  assign len_in      = {len_hi_q, in_byte};
  assign wl_next     = wl_q + WL_ONE;
  assign wl_next_ext = 16'(wl_next);

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    wl_d       = wl_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_byte;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_in;
          if (len_in > 16'(MAX_WORDS)) begin
            state_d = S_ERROR;
          end else if (len_in == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d      = {asm_q[15:0], in_byte};
          csum_d     = csum_q ^ in_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes the word: register the write for the next cycle.
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = wl_q[ADDR_WIDTH-1:0];
            wdata_d = {asm_q, in_byte};
            wl_d    = wl_next;
            if (wl_next_ext == len_q) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_byte == csum_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (restart) begin
          state_d    = S_LEN_HI;
          wl_d       = '0;
          csum_d     = '0;
          byte_cnt_d = '0;
        end
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LEN_HI;
      len_hi_q   <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      wl_q       <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      wl_q       <= wl_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: stream-position model checked every cycle plus literal result checks.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;
  logic        busy;
  logic        cpu_run;
  logic        error;

  int checks = 0;
  int failures = 0;

  imem_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .restart(restart), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .words_loaded(words_loaded), .busy(busy), .cpu_run(cpu_run), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: where we are in the stream (bytes accepted), running XOR, and the outcome.
  int          m_pos;
  int          m_n;
  logic [7:0]  m_nhi;
  logic [7:0]  m_xor;
  logic [31:0] m_acc;
  int          m_res;      // 0 = loading, 1 = image good, 2 = image bad
  logic        m_we;
  logic [7:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_wl;
  logic [39:0] wq[$];

  task automatic model_reset();
    m_pos = 0; m_n = 0; m_nhi = 8'h00; m_xor = 8'h00; m_acc = 32'h0; m_res = 0;
    m_we = 1'b0; m_waddr = 8'h00; m_wdata = 32'h0; m_wl = 0;
  endtask

  task automatic model_step();
    int idx;
    m_we = 1'b0;
    if (m_res != 0) begin
      if (restart) begin
        m_pos = 0; m_xor = 8'h00; m_wl = 0; m_res = 0;
      end
    end else if (in_valid) begin
      if (m_pos == 0) begin
        m_nhi = in_byte;
        m_pos = 1;
      end else if (m_pos == 1) begin
        m_n = int'({m_nhi, in_byte});
        m_pos = 2;
        if (m_n > 256) m_res = 2;
      end else if (m_pos < 2 + 4 * m_n) begin
        m_acc = {m_acc[23:0], in_byte};
        m_xor = m_xor ^ in_byte;
        m_pos = m_pos + 1;
        idx = m_pos - 2;
        if (idx % 4 == 0) begin
          m_we = 1'b1;
          m_waddr = 8'(idx / 4 - 1);
          m_wdata = m_acc;
          m_wl = m_wl + 1;
        end
      end else begin
        m_res = (in_byte == m_xor) ? 1 : 2;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] act;
    logic [63:0] exp;
    if (rst) model_reset();
    act = {10'h0, imem_we, imem_waddr, imem_wdata, words_loaded, busy, cpu_run, error, in_ready};
    exp = {10'h0, m_we, m_waddr, m_wdata, 9'(m_wl), (m_res == 0 && m_pos > 0),
           (m_res == 1), (m_res == 2), (m_res == 0)};
    chk("cycle{we,waddr,wdata,wl,busy,run,err,rdy}", act, exp);
    if (imem_we) wq.push_back({imem_waddr, imem_wdata});
    if (!rst) model_step();
  end

  logic [7:0] seq[$];

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_byte = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input int gap);
    foreach (seq[i]) begin
      send_byte(seq[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_good_writes(input string tag);
    chk({tag, "_nwr"}, 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk({tag, "_w0"}, 64'(wq[0]), {24'h0, 8'h00, 32'h20080005});
      chk({tag, "_w1"}, 64'(wq[1]), {24'h0, 8'h01, 32'h00000000});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    chk("reset_outs", {imem_we, imem_waddr, imem_wdata, words_loaded, busy, cpu_run, error, in_ready},
        {1'b0, 8'h00, 32'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
    idle(2);

    // Valid two-word image
    wq.delete();
    seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    play(0);
    chk("good_run", cpu_run, 1);
    idle(1);
    chk("good_wl", words_loaded, 2);
    chk("good_err", error, 0);
    check_good_writes("good");
    pulse_restart();
    idle(1);

    // Bad checksum
    wq.delete();
    seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};
    play(0);
    idle(1);
    chk("badcs_state", {error, cpu_run, in_ready}, 3'b100);
    check_good_writes("badcs");
    pulse_restart();
    chk("restart_state", {in_ready, words_loaded, error}, {1'b1, 9'h0, 1'b0});
    idle(1);

    // Empty image, good and bad checksum
    wq.delete();
    seq = '{8'h00, 8'h00, 8'h00};
    play(0);
    idle(1);
    chk("empty_run", cpu_run, 1);
    pulse_restart();
    seq = '{8'h00, 8'h00, 8'hFF};
    play(0);
    idle(1);
    chk("empty_bad_err", {error, cpu_run}, 2'b10);
    chk("empty_nwr", 64'(wq.size()), 0);
    pulse_restart();

    // Oversize length
    seq = '{8'h01, 8'h01};
    play(0);
    chk("oversize", {error, busy, in_ready}, 3'b100);
    chk("oversize_nwr", 64'(wq.size()), 0);
    pulse_restart();

    // Gapped input with an ignored restart mid-load
    wq.delete();
    seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    play(3);
    pulse_restart();
    seq = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    play(3);
    chk("gap_run", {cpu_run, error, words_loaded}, {1'b1, 1'b0, 9'd2});
    check_good_writes("gap");
    pulse_restart();

    // Reset asserted mid-load after one word
    wq.delete();
    seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
    play(0);
    chk("midrst_pre_wl", words_loaded, 1);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {imem_we, imem_waddr, imem_wdata, words_loaded, busy, cpu_run, error, in_ready},
        {1'b0, 8'h00, 32'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    idle(2);
    rst = 1'b0;
    idle(1);
    wq.delete();
    seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    play(0);
    chk("reload_run", cpu_run, 1);

    // Bytes offered while DONE are refused
    in_valid = 1'b1;
    in_byte = 8'hAA;
    idle(10);
    in_valid = 1'b0;
    idle(1);
    check_good_writes("done_hold");
    chk("done_hold_state", {cpu_run, in_ready, words_loaded}, {1'b1, 1'b0, 9'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
